// File: rtl/axi_mtimer.sv
// axi_mtimer -- AXI4 responder implementing a RISC-V machine timer.
//
// Registers: 64-bit mtime, 64-bit mtimecmp, ctrl (en, irq_pending) and a
// prescaler. mtime advances once every (presc+1) clk cycles while en=1.
// timer_irq_o is a registered level: en & (mtime >= mtimecmp).
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-low reset
//   axi_mosi     AW, W, B-ready, AR, R-ready from the interconnect
//   axi_miso     AW/W/AR ready, B and R channels to the interconnect
//   timer_irq_o  machine timer interrupt, level
//   mtime_o      current mtime value
//
// Write FSM
//   state   | meaning
//   W_IDLE  | collecting AW and W into holding registers
//   W_DRAIN | burst write: swallowing W beats until wlast
//   W_RESP  | bvalid high, waiting for bready
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high
//   R_DATA  | rvalid high, beats remaining in rcnt

package axi_mtimer_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

module axi_mtimer
  import axi_mtimer_pkg::*;
#(
  parameter logic [31:0] PRESC_RST  = 32'd0,
  parameter int          ADDR_DEC_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        timer_irq_o,
  output logic [63:0] mtime_o
);

  localparam int IDX_W = ADDR_DEC_W - 2;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}          rstate_t;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  // timer registers
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        irq_q, irq_d;

  // write side
  wstate_t              wstate_q, wstate_d;
  logic                 aw_have_q, aw_have_d;
  logic [AXI_ID_W-1:0]  aw_id_q, aw_id_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [7:0]           aw_len_q, aw_len_d;
  logic                 w_have_q, w_have_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic                 w_last_q, w_last_d;
  logic [AXI_ID_W-1:0]  bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;

  // read side
  rstate_t              rstate_q, rstate_d;
  logic [AXI_ID_W-1:0]  rid_q, rid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [7:0]           rcnt_q, rcnt_d;

  logic                 awready, wready, aw_hs, w_hs;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic [AXI_ID_W-1:0]  cur_id;
  logic [7:0]           cur_len;
  logic                 cur_last;
  logic [IDX_W-1:0]     ar_idx;
  logic [31:0]          rd_mux;
  logic                 tick;

  logic unused_addr;
  assign unused_addr = ^{axi_mosi.awaddr[AXI_ADDR_W-1:ADDR_DEC_W], axi_mosi.awaddr[1:0],
                         axi_mosi.araddr[AXI_ADDR_W-1:ADDR_DEC_W], axi_mosi.araddr[1:0]};

  // ---------------- write FSM ----------------
  always_comb begin
    wstate_d  = wstate_q;
    aw_have_d = aw_have_q;
    aw_id_d   = aw_id_q;
    aw_idx_d  = aw_idx_q;
    aw_len_d  = aw_len_q;
    w_have_d  = w_have_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_last_d  = w_last_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    awready   = 1'b0;
    wready    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    wr_en     = 1'b0;
    // held values win; otherwise the beat handshaking this cycle is used
    cur_id    = aw_have_q ? aw_id_q  : axi_mosi.awid;
    cur_len   = aw_have_q ? aw_len_q : axi_mosi.awlen;
    cur_last  = w_have_q  ? w_last_q : axi_mosi.wlast;
    wr_idx    = aw_have_q ? aw_idx_q : axi_mosi.awaddr[ADDR_DEC_W-1:2];
    wr_data   = w_have_q  ? w_data_q : axi_mosi.wdata;
    wr_strb   = w_have_q  ? w_strb_q : axi_mosi.wstrb;

    case (wstate_q)
      W_IDLE: begin
        awready = rst && !aw_have_q;
        wready  = rst && !w_have_q;
        aw_hs   = awready && axi_mosi.awvalid;
        w_hs    = wready && axi_mosi.wvalid;
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bid_d     = cur_id;
          if (cur_len == 8'd0) begin
            wr_en    = 1'b1;
            bresp_d  = RESP_OKAY;
            wstate_d = W_RESP;
          end else begin
            bresp_d  = RESP_SLVERR;
            wstate_d = cur_last ? W_RESP : W_DRAIN;
          end
        end else begin
          if (aw_hs) begin
            aw_have_d = 1'b1;
            aw_id_d   = axi_mosi.awid;
            aw_idx_d  = axi_mosi.awaddr[ADDR_DEC_W-1:2];
            aw_len_d  = axi_mosi.awlen;
          end
          if (w_hs) begin
            w_have_d = 1'b1;
            w_data_d = axi_mosi.wdata;
            w_strb_d = axi_mosi.wstrb;
            w_last_d = axi_mosi.wlast;
          end
        end
      end
      W_DRAIN: begin
        wready = rst;
        if (axi_mosi.wvalid && axi_mosi.wlast) wstate_d = W_RESP;
      end
      W_RESP: begin
        if (axi_mosi.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // ---------------- timer registers ----------------
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    // >= rather than == so shrinking presc below a running count cannot
    // send the counter around a full 32-bit wrap
    tick       = en_q && (pcnt_q >= presc_q);
    if (en_q) pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;

    // a software write to either mtime half suppresses that cycle's increment
    if (wr_en && (wr_idx == IDX_W'(0) || wr_idx == IDX_W'(1))) begin
      if (wr_idx == IDX_W'(0)) mtime_d[31:0]  = merge(mtime_q[31:0],  wr_data, wr_strb);
      else                     mtime_d[63:32] = merge(mtime_q[63:32], wr_data, wr_strb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_en && wr_idx == IDX_W'(2)) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  wr_data, wr_strb);
    if (wr_en && wr_idx == IDX_W'(3)) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_data, wr_strb);
    if (wr_en && wr_idx == IDX_W'(4) && wr_strb[0]) en_d = wr_data[0];
    if (wr_en && wr_idx == IDX_W'(5)) presc_d = merge(presc_q, wr_data, wr_strb);

    irq_d = en_q && (mtime_q >= mtimecmp_q);
  end

  // ---------------- read FSM ----------------
  assign ar_idx = axi_mosi.araddr[ADDR_DEC_W-1:2];

  always_comb begin
    rd_mux = 32'd0;
    case (ar_idx)
      IDX_W'(0): rd_mux = mtime_q[31:0];
      IDX_W'(1): rd_mux = mtime_q[63:32];
      IDX_W'(2): rd_mux = mtimecmp_q[31:0];
      IDX_W'(3): rd_mux = mtimecmp_q[63:32];
      IDX_W'(4): rd_mux = {30'd0, irq_q, en_q};
      IDX_W'(5): rd_mux = presc_q;
      default:   rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rcnt_d   = rcnt_q;
    case (rstate_q)
      R_IDLE: begin
        if (axi_mosi.arvalid) begin
          rid_d    = axi_mosi.arid;
          rcnt_d   = axi_mosi.arlen;
          rstate_d = R_DATA;
          if (axi_mosi.arlen == 8'd0) begin
            rdata_d = rd_mux;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (axi_mosi.rready) begin
          if (rcnt_q == 8'd0) rstate_d = R_IDLE;
          else                rcnt_d   = rcnt_q - 8'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = awready;
    axi_miso.wready  = wready;
    axi_miso.bvalid  = rst && (wstate_q == W_RESP);
    axi_miso.bid     = bid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.arready = rst && (rstate_q == R_IDLE);
    axi_miso.rvalid  = rst && (rstate_q == R_DATA);
    axi_miso.rid     = rid_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = (rstate_q == R_DATA) && (rcnt_q == 8'd0);
  end

  assign timer_irq_o = irq_q;
  assign mtime_o     = mtime_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      presc_q    <= PRESC_RST;
      pcnt_q     <= 32'd0;
      irq_q      <= 1'b0;
      wstate_q   <= W_IDLE;
      aw_have_q  <= 1'b0;
      aw_id_q    <= '0;
      aw_idx_q   <= '0;
      aw_len_q   <= 8'd0;
      w_have_q   <= 1'b0;
      w_data_q   <= 32'd0;
      w_strb_q   <= 4'd0;
      w_last_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      rstate_q   <= R_IDLE;
      rid_q      <= '0;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
      rcnt_q     <= 8'd0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
      wstate_q   <= wstate_d;
      aw_have_q  <= aw_have_d;
      aw_id_q    <= aw_id_d;
      aw_idx_q   <= aw_idx_d;
      aw_len_q   <= aw_len_d;
      w_have_q   <= w_have_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      w_last_q   <= w_last_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rstate_q   <= rstate_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rcnt_q     <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_axi_mtimer.sv
// Directed testbench for axi_mtimer.
module tb_axi_mtimer;
  import axi_mtimer_pkg::*;

  logic        clk;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        irq;
  logic [63:0] mtime;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic [1:0]  resp;
  logic        last;
  logic [3:0]  id_o;
  logic [63:0] v;
  int          n;
  int          beats;
  int          bseen;
  logic        ar_hs, aw_hs, w_hs;

  axi_mtimer #(.PRESC_RST(32'd0), .ADDR_DEC_W(5)) dut (
    .clk(clk), .rst(rst), .axi_mosi(mosi), .axi_miso(miso),
    .timer_irq_o(irq), .mtime_o(mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [3:0] id,
                          output logic [1:0] bresp_o, output logic [3:0] bid_o);
    bit aw_d, w_d;
    int k;
    aw_d = 0; w_d = 0; k = 0;
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    mosi.bready = 1'b1;
    while (!(aw_d && w_d) && k < 50) begin
      @(negedge clk);
      if (miso.awready && mosi.awvalid) aw_d = 1;
      if (miso.wready && mosi.wvalid) w_d = 1;
      @(posedge clk); #1;
      if (aw_d) mosi.awvalid = 1'b0;
      if (w_d)  mosi.wvalid  = 1'b0;
      k++;
    end
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (miso.bvalid) break;
      k++;
    end
    chk("wr_b_timeout", 64'(k < 50), 64'd1);
    bresp_o = miso.bresp;
    bid_o   = miso.bid;
    @(posedge clk); #1;
    mosi.bready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    logic [3:0] b;
    do_write(addr, data, 4'hF, 4'h1, r, b);
    chk("wr_bresp", 64'(r), 64'(RESP_OKAY));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         output logic [31:0] data_o, output logic [1:0] resp_o,
                         output logic last_o, output logic [3:0] rid_o);
    int k;
    k = 0;
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = 8'd0; mosi.arvalid = 1'b1;
    mosi.rready = 1'b0;
    do begin @(negedge clk); k++; end while (!miso.arready && k < 50);
    @(posedge clk); #1;
    mosi.arvalid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!miso.rvalid && k < 50);
    chk("rd_timeout", 64'(k < 50), 64'd1);
    data_o = miso.rdata; resp_o = miso.rresp; last_o = miso.rlast; rid_o = miso.rid;
    mosi.rready = 1'b1;
    @(posedge clk); #1;
    mosi.rready = 1'b0;
  endtask

  initial begin
    mosi = '0;
    rst  = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(miso.awready), 64'd0);
    chk("rst_arready", 64'(miso.arready), 64'd0);
    chk("rst_bvalid",  64'(miso.bvalid),  64'd0);
    chk("rst_rvalid",  64'(miso.rvalid),  64'd0);
    chk("rst_irq",     64'(irq),          64'd0);
    chk("rst_mtime",   mtime,             64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_read(32'h08, 4'h2, rd, resp, last, id_o);
    chk("rd_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    chk("rd_cmp_lo_resp", 64'(resp), 64'(RESP_OKAY));
    chk("rd_cmp_lo_last", 64'(last), 64'd1);
    chk("rd_cmp_lo_rid", 64'(id_o), 64'h2);
    do_read(32'h0C, 4'h3, rd, resp, last, id_o);
    chk("rd_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    do_read(32'h10, 4'h4, rd, resp, last, id_o);
    chk("rd_ctrl_rst", 64'(rd), 64'h0);
    chk("irq_after_rst", 64'(irq), 64'd0);

    // ---- prescaled counting and interrupt ----
    wr(32'h14, 32'd3);
    wr(32'h08, 32'd10);
    wr(32'h0C, 32'd0);
    wr(32'h10, 32'd1);
    v = mtime; n = 0;
    while (mtime == v && n < 20) begin @(negedge clk); n++; end
    v = mtime; n = 0;
    do begin @(negedge clk); n++; end while (mtime == v && n < 20);
    chk("presc_period", 64'(n), 64'd4);
    n = 0;
    while (mtime != 64'd10 && n < 100) begin @(negedge clk); n++; end
    chk("reach10_timeout", 64'(n < 100), 64'd1);
    chk("irq_same_cycle", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_rise", 64'(irq), 64'd1);
    do_read(32'h10, 4'h5, rd, resp, last, id_o);
    chk("rd_ctrl_pend", 64'(rd), 64'h3);

    // ---- carry into upper half ----
    wr(32'h10, 32'd0);
    wr(32'h14, 32'd0);
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h04, 32'h0);
    chk("mtime_loaded", mtime, 64'h0000_0000_FFFF_FFFF);
    wr(32'h10, 32'd1);
    n = 0;
    while (mtime == 64'h0000_0000_FFFF_FFFF && n < 20) begin @(negedge clk); n++; end
    chk("carry", mtime, 64'h1_0000_0000);
    do_read(32'h04, 4'h6, rd, resp, last, id_o);
    chk("rd_mtime_hi", 64'(rd), 64'h1);
    wr(32'h10, 32'd0);

    // ---- W leads AW by 3 cycles, byte strobe ----
    mosi.wdata = 32'h0000_AB00; mosi.wstrb = 4'b0010; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    @(negedge clk);
    chk("w_first_ready", 64'(miso.wready), 64'd1);
    @(posedge clk); #1;
    mosi.wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mosi.awid = 4'h5; mosi.awaddr = 32'h08; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    @(negedge clk);
    chk("aw_ready", 64'(miso.awready), 64'd1);
    chk("b_not_early", 64'(miso.bvalid), 64'd0);
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    @(negedge clk);
    chk("b_latency", 64'(miso.bvalid), 64'd1);
    chk("b_id", 64'(miso.bid), 64'h5);
    chk("b_resp", 64'(miso.bresp), 64'(RESP_OKAY));
    mosi.bready = 1'b1;
    @(posedge clk); #1;
    mosi.bready = 1'b0;
    @(negedge clk);
    chk("b_done", 64'(miso.bvalid), 64'd0);
    do_read(32'h08, 4'h7, rd, resp, last, id_o);
    chk("rd_strb_lo", 64'(rd), 64'h0000_AB0A);
    do_read(32'h0C, 4'h7, rd, resp, last, id_o);
    chk("rd_strb_hi", 64'(rd), 64'h0);

    // ---- read burst with concurrent write ----
    mosi.arid = 4'h3; mosi.araddr = 32'h00; mosi.arlen = 8'd2; mosi.arvalid = 1'b1;
    mosi.awid = 4'h9; mosi.awaddr = 32'h14; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    mosi.wdata = 32'd7; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    mosi.bready = 1'b1; mosi.rready = 1'b0;
    beats = 0; bseen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ar_hs = mosi.arvalid && miso.arready;
      aw_hs = mosi.awvalid && miso.awready;
      w_hs  = mosi.wvalid && miso.wready;
      if (miso.rvalid && mosi.rready) begin
        beats++;
        chk("burst_rdata", 64'(miso.rdata), 64'h0);
        chk("burst_rresp", 64'(miso.rresp), 64'(RESP_SLVERR));
        chk("burst_rlast", 64'(miso.rlast), 64'(beats == 3));
        chk("burst_rid", 64'(miso.rid), 64'h3);
      end
      if (miso.bvalid && mosi.bready) begin
        bseen++;
        chk("conc_bresp", 64'(miso.bresp), 64'(RESP_OKAY));
        chk("conc_bid", 64'(miso.bid), 64'h9);
      end
      @(posedge clk); #1;
      if (ar_hs) mosi.arvalid = 1'b0;
      if (aw_hs) mosi.awvalid = 1'b0;
      if (w_hs)  mosi.wvalid  = 1'b0;
      mosi.rready = ~mosi.rready;
    end
    mosi.rready = 1'b0; mosi.bready = 1'b0;
    chk("burst_beats", 64'(beats), 64'd3);
    chk("conc_bcount", 64'(bseen), 64'd1);
    do_read(32'h14, 4'h1, rd, resp, last, id_o);
    chk("rd_presc", 64'(rd), 64'd7);

    // ---- reset while B is pending ----
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd1);
    mosi.awid = 4'hA; mosi.awaddr = 32'h08; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    mosi.wdata = 32'h1234; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    mosi.bready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    @(negedge clk);
    chk("pend_bvalid", 64'(miso.bvalid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_bvalid", 64'(miso.bvalid), 64'd0);
    chk("mid_rst_mtime", mtime, 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mosi.bready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (miso.bvalid) n++;
    end
    mosi.bready = 1'b0;
    chk("no_stale_b", 64'(n), 64'd0);
    @(posedge clk); #1;
    do_read(32'h10, 4'h2, rd, resp, last, id_o);
    chk("rd_ctrl_after_rst", 64'(rd), 64'h0);
    do_read(32'h08, 4'h2, rd, resp, last, id_o);
    chk("rd_cmp_after_rst", 64'(rd), 64'hFFFF_FFFF);
    chk("mtime_held", mtime, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
